// File: rtl/fifo_rd_upsizer.sv
// Read-side consumer for the async FIFO: drains narrow words and packs RATIO of them
// into one wide word on a valid/ready output, with a flush that emits a partial word.
module fifo_rd_upsizer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RATIO      = 4,
  localparam int CNT_WIDTH  = $clog2(RATIO) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifoEmpty,
  input  logic [DATA_WIDTH-1:0]       fifoRData,
  output logic                        fifoREn,
  input  logic                        flush,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [DATA_WIDTH*RATIO-1:0] outData,
  output logic [CNT_WIDTH-1:0]        outCount
);

  localparam int                   IDX_WIDTH = $clog2(RATIO);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(RATIO - 1);

  logic [DATA_WIDTH-1:0]       acc_q [RATIO-1];
  logic [IDX_WIDTH-1:0]        acc_cnt_q, acc_cnt_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH*RATIO-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;

  logic out_free, last_lane, rd_en, load_full, load_flush;

  assign out_free   = !out_valid_q || outReady;
  assign last_lane  = (acc_cnt_q == LAST_IDX);
  // The FIFO pointer is unguarded, so a read is only ever issued with data present.
  assign rd_en      = !rst && !fifoEmpty && !flush_pend_q && (!last_lane || out_free);
  assign load_full  = rd_en && last_lane;
  assign load_flush = flush_pend_q && out_free && (acc_cnt_q != '0);

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;

    if (load_full || load_flush) begin
      acc_cnt_d = '0;
    end else if (rd_en) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end

    // A pending flush retires once the partial word is out, or at once if nothing is held.
    if (flush_pend_q) begin
      flush_pend_d = !(load_flush || (acc_cnt_q == '0));
    end else begin
      flush_pend_d = flush;
    end

    if (load_full) begin
      out_data_d = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
      end
      out_data_d[(RATIO-1)*DATA_WIDTH +: DATA_WIDTH] = fifoRData;
      out_count_d = CNT_WIDTH'(RATIO);
      out_valid_d = 1'b1;
    end else if (load_flush) begin
      out_data_d = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
        if (i < int'(acc_cnt_q)) begin
          out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
        end
      end
      out_count_d = CNT_WIDTH'(acc_cnt_q);
      out_valid_d = 1'b1;
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
    end else begin
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
    end
  end

  // NOTE: the accumulator lanes have no reset; acc_cnt_q masks every lane not yet written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RATIO - 1; i++) begin
      if (rd_en && (acc_cnt_q == IDX_WIDTH'(i))) begin
        acc_q[i] <= fifoRData;
      end
    end
  end

  assign fifoREn  = rd_en;
  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outCount = out_count_q;

endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Self-checking bench for fifo_rd_upsizer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fifo_rd_upsizer;

  localparam int DW    = 32;
  localparam int RATIO = 4;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst, fifoEmpty, fifoREn, flush, outValid, outReady;
  logic [DW-1:0]     fifoRData;
  logic [DW*RATIO-1:0] outData;
  logic [CW-1:0]     outCount;

  always #5 clk = ~clk;

  // FIFO stand-in: array with read/write pointers, plus a control to force empty.
  logic [DW-1:0] mem [1024];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic          force_empty;

  assign fifoEmpty = force_empty || (rd_ptr == wr_ptr);
  assign fifoRData = mem[rd_ptr % 1024];

  fifo_rd_upsizer #(.DATA_WIDTH(DW), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifoEmpty (fifoEmpty),
    .fifoRData (fifoRData),
    .fifoREn   (fifoREn),
    .flush     (flush),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData),
    .outCount  (outCount)
  );

  // Reference model state
  logic [DW-1:0]       acc_m [$];
  bit                  out_v_m, fp_m;
  logic [DW*RATIO-1:0] out_d_m;
  int                  out_c_m;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ren();
    if (rst || fifoEmpty || fp_m) return 1'b0;
    return (acc_m.size() < RATIO - 1) || !out_v_m || outReady;
  endfunction

  task automatic model_emit();
    out_d_m = '0;
    foreach (acc_m[i]) out_d_m[i*DW +: DW] = acc_m[i];
    out_c_m = acc_m.size();
    out_v_m = 1'b1;
    acc_m.delete();
  endtask

  task automatic model_step();
    bit ren, free, loaded, fp_old;
    int n;
    if (rst) begin
      acc_m.delete();
      out_v_m = 1'b0;
      out_d_m = '0;
      out_c_m = 0;
      fp_m    = 1'b0;
      return;
    end
    free   = !out_v_m || outReady;
    fp_old = fp_m;
    ren    = model_ren();
    n      = acc_m.size();
    loaded = 1'b0;
    if (ren) begin
      acc_m.push_back(fifoRData);
      rd_ptr <= rd_ptr + 1;
      if (acc_m.size() == RATIO) begin
        model_emit();
        loaded = 1'b1;
      end
    end else if (fp_old && free && n > 0) begin
      model_emit();
      loaded = 1'b1;
    end
    if (fp_old) fp_m = !(loaded || n == 0);
    else        fp_m = flush;
    if (!loaded && out_v_m && outReady) out_v_m = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_ren", fifoREn, model_ren());
      check("model_valid", outValid, out_v_m);
      check("ren_while_empty", fifoREn && fifoEmpty, 0);
      if (out_v_m) begin
        check("model_data", outData, out_d_m);
        check("model_count", outCount, out_c_m[CW-1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] nxt;
    rst = 1'b1; flush = 1'b0; outReady = 1'b1; force_empty = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));

    // Reset with a non-empty FIFO
    repeat (3) begin
      tick();
      chk_en = 1'b1;
      check("rst_ren", fifoREn, 0);
      check("rst_valid", outValid, 0);
      check("rst_data", outData, 0);
      check("rst_count", outCount, 0);
    end

    // Streaming at full rate
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("stream_ren", fifoREn, 1);
      tick();
      #1;
      if (i == 3) begin
        check("stream_w1_valid", outValid, 1);
        check("stream_w1_data", outData, 128'h00000004_00000003_00000002_00000001);
        check("stream_w1_count", outCount, 4);
      end
      if (i == 7) begin
        check("stream_w2_valid", outValid, 1);
        check("stream_w2_data", outData, 128'h00000008_00000007_00000006_00000005);
      end
    end
    check("stream_ren_empty", fifoREn, 0);
    tick();
    check("stream_drained", outValid, 0);

    // Backpressure: first word held, three more accumulated, then reads stop
    outReady = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int k = 0; k < 12; k++) begin
      tick();
      #1;
      if (k >= 3) begin
        check("bp_hold_valid", outValid, 1);
        check("bp_hold_data", outData, 128'h00000004_00000003_00000002_00000001);
      end
    end
    check("bp_ren_blocked", fifoREn, 0);
    outReady = 1'b1;
    #1;
    check("bp_ren_release", fifoREn, 1);
    tick();
    #1;
    check("bp_w2_valid", outValid, 1);
    check("bp_w2_data", outData, 128'h00000008_00000007_00000006_00000005);
    check("bp_w2_count", outCount, 4);
    tick();
    check("bp_drained", outValid, 0);

    // Partial flush of two words
    push(32'hA); push(32'hB);
    tick(); tick();
    flush = 1'b1;
    #1;
    check("pf_ren_empty", fifoREn, 0);
    tick();
    flush = 1'b0;
    #1;
    check("pf_not_yet", outValid, 0);
    tick();
    #1;
    check("pf_valid", outValid, 1);
    check("pf_count", outCount, 2);
    check("pf_data", outData, 128'h00000000_00000000_0000000B_0000000A);
    tick();

    // Flush with nothing accumulated
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h11 + i));
    #1;
    check("ef_ren_pend", fifoREn, 0);
    tick();
    #1;
    check("ef_no_word", outValid, 0);
    check("ef_ren_resume", fifoREn, 1);
    repeat (4) tick();
    #1;
    check("ef_word_data", outData, 128'h00000014_00000013_00000012_00000011);
    check("ef_word_count", outCount, 4);
    tick();

    // Flush coinciding with the RATIO-th read
    for (int i = 0; i < 5; i++) push(DW'(32'h21 + i));
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("cf_valid", outValid, 1);
    check("cf_count", outCount, 4);
    check("cf_data", outData, 128'h00000024_00000023_00000022_00000021);
    check("cf_ren_pend", fifoREn, 0);
    tick();
    #1;
    check("cf_no_extra", outValid, 0);
    check("cf_ren_resume", fifoREn, 1);
    for (int i = 0; i < 3; i++) push(DW'(32'h26 + i));
    repeat (4) tick();
    #1;
    check("cf_next_data", outData, 128'h00000028_00000027_00000026_00000025);
    tick();

    // Random empty/ready/flush stress, checked by the model every cycle
    nxt = 32'h100;
    for (int i = 0; i < 300; i++) begin
      force_empty = ($urandom_range(0, 3) == 0);
      outReady    = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        push(nxt);
        nxt++;
      end
      tick();
    end
    force_empty = 1'b0; outReady = 1'b1; flush = 1'b0;
    repeat (120) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();

    // Reset after three accumulated words
    for (int i = 0; i < 8; i++) push(DW'(32'h31 + i));
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rr_ren_in_rst", fifoREn, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    #1;
    check("rr_valid", outValid, 1);
    check("rr_lane0", outData[DW-1:0], 32'h34);
    check("rr_data", outData, 128'h00000037_00000036_00000035_00000034);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
